ex_mem_stage: RTL and testbench

- Execute-to-memory pipeline stage of the 5-stage MIPS datapath.
- Latches execute results (ALU out, next PC, LUI value, store data after forwarding select), destination and write-back control, and memory-op control.
- Runs the data-memory request handshake and stalls the front of the pipe until the access completes.
- Its registered outputs are the `*_me` operands the forwarding unit consumes for JR and ALU/store forwarding.

---
 rtl/ex_mem_stage.sv | 138 +++++++++++++
 tb/tb_ex_mem_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register of the 5-stage MIPS datapath.
// Holds the ME operands for forwarding/write-back and runs the data-memory request.
module ex_mem_stage #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DW-1:0]   ALUOut_ex,
  input  logic [DW-1:0]   npc_ex,
  input  logic [DW-1:0]   lui_ex,
  input  logic [DW-1:0]   dmemstore_ex,
  input  logic [DW-1:0]   forDmemstore_ex,
  input  logic            srcDmemstore_ex,
  input  logic [4:0]      regDst_ex,
  input  logic            regWr_ex,
  input  logic [1:0]      regSel_ex,
  input  logic            dREN_ex,
  input  logic            dWEN_ex,
  input  logic            halt_ex,
  input  logic            flush_ex,
  input  logic            dhit,
  input  logic [DW-1:0]   dload,
  output logic [DW-1:0]   ALUOut_me,
  output logic [DW-1:0]   npc_me,
  output logic [DW-1:0]   lui_me,
  output logic [DW-1:0]   dmemload_me,
  output logic [4:0]      regDst_me,
  output logic            regWr_me,
  output logic [1:0]      regSel_me,
  output logic            halt_me,
  output logic [DW-1:0]   dmemaddr,
  output logic [DW-1:0]   dmemstore,
  output logic            dmemREN,
  output logic            dmemWEN,
  output logic            stall_me,
  output logic [CNTW-1:0] memstall_cnt,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_dren_q;
  logic   r_dwen_q;
  logic   w_memop;
  logic   w_advance;
  logic   w_bubble;
  logic   w_in_dren;
  logic   w_in_dwen;

  // Memory handshake: a strobe is held high for the whole REQ state and the
  // access completes on the first cycle dhit is sampled high; dhit elsewhere
  // is ignored. Strobes drop combinationally while RST is asserted.
  assign w_memop   = r_dren_q | r_dwen_q;
  assign w_bubble  = flush_ex | halt_me;
  assign w_in_dwen = dWEN_ex & ~w_bubble;
  assign w_in_dren = dREN_ex & ~dWEN_ex & ~w_bubble;

  always_comb begin
    w_next    = r_state;
    w_advance = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_memop) w_next = REQ;
        else         w_advance = 1'b1;
      end
      REQ: begin
        if (dhit) w_next = DONE;
      end
      DONE: begin
        w_advance = 1'b1;
        w_next    = (w_in_dren | w_in_dwen) ? REQ : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ALUOut_me <= '0;
      npc_me    <= '0;
      lui_me    <= '0;
      dmemstore <= '0;
      regDst_me <= '0;
      regWr_me  <= 1'b0;
      regSel_me <= '0;
      halt_me   <= 1'b0;
      r_dren_q  <= 1'b0;
      r_dwen_q  <= 1'b0;
    end else if (w_advance) begin
      ALUOut_me <= ALUOut_ex;
      npc_me    <= npc_ex;
      lui_me    <= lui_ex;
      dmemstore <= srcDmemstore_ex ? forDmemstore_ex : dmemstore_ex;
      regDst_me <= regDst_ex;
      regSel_me <= regSel_ex;
      regWr_me  <= regWr_ex & ~w_bubble;
      r_dren_q  <= w_in_dren;
      r_dwen_q  <= w_in_dwen;
      // Halt is sticky: once seen it stays set until reset.
      halt_me   <= halt_me | (halt_ex & ~flush_ex);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dmemload_me  <= '0;
      memstall_cnt <= '0;
    end else if (r_state == REQ) begin
      if (dhit) begin
        if (r_dren_q) dmemload_me <= dload;
      end else if (memstall_cnt != {CNTW{1'b1}}) begin
        memstall_cnt <= memstall_cnt + 1'b1;
      end
    end
  end

  assign dmemaddr    = ALUOut_me;
  assign dmemREN     = (r_state == REQ) & r_dren_q & ~RST;
  assign dmemWEN     = (r_state == REQ) & r_dwen_q & ~RST;
  assign stall_me    = ~w_advance;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: table of single-cycle ALU vectors plus
// hand-written load, store, flush, reset-mid-access and halt sequences.
module tb_ex_mem_stage;
  localparam int DW   = 32;
  localparam int CNTW = 16;

  logic            CLK;
  logic            RST;
  logic [DW-1:0]   ALUOut_ex, npc_ex, lui_ex, dmemstore_ex, forDmemstore_ex;
  logic            srcDmemstore_ex;
  logic [4:0]      regDst_ex;
  logic            regWr_ex;
  logic [1:0]      regSel_ex;
  logic            dREN_ex, dWEN_ex, halt_ex, flush_ex, dhit;
  logic [DW-1:0]   dload;
  logic [DW-1:0]   ALUOut_me, npc_me, lui_me, dmemload_me, dmemaddr, dmemstore;
  logic [4:0]      regDst_me;
  logic            regWr_me, halt_me, dmemREN, dmemWEN, stall_me;
  logic [1:0]      regSel_me;
  logic [CNTW-1:0] memstall_cnt;
  logic [1:0]      dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];

  ex_mem_stage #(.DW(DW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST),
    .ALUOut_ex(ALUOut_ex), .npc_ex(npc_ex), .lui_ex(lui_ex),
    .dmemstore_ex(dmemstore_ex), .forDmemstore_ex(forDmemstore_ex),
    .srcDmemstore_ex(srcDmemstore_ex), .regDst_ex(regDst_ex),
    .regWr_ex(regWr_ex), .regSel_ex(regSel_ex), .dREN_ex(dREN_ex),
    .dWEN_ex(dWEN_ex), .halt_ex(halt_ex), .flush_ex(flush_ex),
    .dhit(dhit), .dload(dload),
    .ALUOut_me(ALUOut_me), .npc_me(npc_me), .lui_me(lui_me),
    .dmemload_me(dmemload_me), .regDst_me(regDst_me), .regWr_me(regWr_me),
    .regSel_me(regSel_me), .halt_me(halt_me), .dmemaddr(dmemaddr),
    .dmemstore(dmemstore), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .stall_me(stall_me), .memstall_cnt(memstall_cnt), .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver tasks
  task automatic drive_nop(input logic [DW-1:0] alu);
    ALUOut_ex = alu; npc_ex = '0; lui_ex = '0;
    dmemstore_ex = '0; forDmemstore_ex = '0; srcDmemstore_ex = 1'b0;
    regDst_ex = 5'd9; regWr_ex = 1'b1; regSel_ex = 2'b00;
    dREN_ex = 1'b0; dWEN_ex = 1'b0; halt_ex = 1'b0; flush_ex = 1'b0;
  endtask

  task automatic drive_mem(input logic [DW-1:0] alu, input logic ren, input logic wen,
                           input logic src, input logic [DW-1:0] raw, input logic [DW-1:0] fwd);
    drive_nop(alu);
    dREN_ex = ren; dWEN_ex = wen; srcDmemstore_ex = src;
    dmemstore_ex = raw; forDmemstore_ex = fwd; regSel_ex = ren ? 2'b11 : 2'b00;
    regDst_ex = 5'd8; regWr_ex = ren;
  endtask

  typedef struct {
    logic [DW-1:0] alu, npc, lui;
    logic [4:0]    dst;
    logic          wr;
    logic [1:0]    sel;
    logic          flush;
    logic          chk_data;
    logic [DW-1:0] exp_alu, exp_npc, exp_lui;
    logic [4:0]    exp_dst;
    logic          exp_wr;
    logic [1:0]    exp_sel;
  } vec_t;

  vec_t vecs[5];
  int stall_n, ren_n, wen_n;

  initial begin
    vecs[0] = '{32'h0000_1234, 32'h4,  32'h0, 5'd5,  1'b1, 2'b00, 1'b0, 1'b1,
                32'h0000_1234, 32'h4,  32'h0, 5'd5,  1'b1, 2'b00};
    vecs[1] = '{32'hFFFF_FFFF, 32'h100, 32'hABCD_0000, 5'd31, 1'b1, 2'b01, 1'b0, 1'b1,
                32'hFFFF_FFFF, 32'h100, 32'hABCD_0000, 5'd31, 1'b1, 2'b01};
    vecs[2] = '{32'h0, 32'h8, 32'h1234_0000, 5'd0, 1'b0, 2'b10, 1'b0, 1'b1,
                32'h0, 32'h8, 32'h1234_0000, 5'd0, 1'b0, 2'b10};
    vecs[3] = '{32'h8000_0000, 32'hC, 32'h0, 5'd7, 1'b1, 2'b11, 1'b1, 1'b0,
                32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00};
    vecs[4] = '{32'h5A5A_A5A5, 32'h10, 32'h7, 5'd12, 1'b1, 2'b00, 1'b0, 1'b1,
                32'h5A5A_A5A5, 32'h10, 32'h7, 5'd12, 1'b1, 2'b00};

    drive_nop('0); regWr_ex = 1'b0; dhit = 1'b0; dload = '0;
    RST = 1'b1;
    step(); step();
    check("rst_alu", ALUOut_me, '0);
    check("rst_regwr", {31'b0, regWr_me}, 32'd0);
    check("rst_halt", {31'b0, halt_me}, 32'd0);
    check("rst_cnt", {16'b0, memstall_cnt}, 32'd0);
    check("rst_store", dmemstore, '0);
    check("rst_load", dmemload_me, '0);
    check("rst_strobes", {30'b0, dmemREN, dmemWEN}, 32'd0);
    RST = 1'b0;

    // Table of single-cycle non-memory vectors
    for (int i = 0; i < 5; i++) begin
      drive_nop(vecs[i].alu);
      npc_ex = vecs[i].npc; lui_ex = vecs[i].lui; regDst_ex = vecs[i].dst;
      regWr_ex = vecs[i].wr; regSel_ex = vecs[i].sel; flush_ex = vecs[i].flush;
      exp_q.push_back(vecs[i].exp_alu);
      step();
      check($sformatf("v%0d_regwr", i), {31'b0, regWr_me}, {31'b0, vecs[i].exp_wr});
      check($sformatf("v%0d_stall", i), {31'b0, stall_me}, 32'd0);
      check($sformatf("v%0d_strobes", i), {30'b0, dmemREN, dmemWEN}, 32'd0);
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_alu", i), ALUOut_me, exp_q.pop_front());
        check($sformatf("v%0d_npc", i), npc_me, vecs[i].exp_npc);
        check($sformatf("v%0d_lui", i), lui_me, vecs[i].exp_lui);
        check($sformatf("v%0d_dst", i), {27'b0, regDst_me}, {27'b0, vecs[i].exp_dst});
        check($sformatf("v%0d_sel", i), {30'b0, regSel_me}, {30'b0, vecs[i].exp_sel});
      end else begin
        void'(exp_q.pop_front());
      end
    end

    // Load: dhit on the third REQ cycle
    drive_mem(32'h40, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_nop(32'h99);
    stall_n = 0; ren_n = 0;
    for (int c = 0; c < 4; c++) begin
      if (stall_me) stall_n++;
      if (dmemREN) ren_n++;
      if (c == 3) begin dhit = 1'b1; dload = 32'hDEAD_BEEF; end
      else begin dhit = 1'b0; dload = '0; end
      step();
    end
    dhit = 1'b0; dload = '0;
    check("ld_stall_cycles", stall_n, 32'd4);
    check("ld_ren_cycles", ren_n, 32'd3);
    check("ld_done_stall", {31'b0, stall_me}, 32'd0);
    check("ld_done_ren", {31'b0, dmemREN}, 32'd0);
    check("ld_addr", dmemaddr, 32'h40);
    check("ld_data", dmemload_me, 32'hDEAD_BEEF);
    check("ld_cnt", {16'b0, memstall_cnt}, 32'd2);
    step();
    check("ld_next_alu", ALUOut_me, 32'h99);
    check("ld_hold_data", dmemload_me, 32'hDEAD_BEEF);

    // Store with forwarded data, dhit on the second REQ cycle
    drive_mem(32'h80, 1'b0, 1'b1, 1'b1, 32'h1, 32'hAAAA_5555);
    step();
    check("st_data", dmemstore, 32'hAAAA_5555);
    drive_nop(32'h9A);
    wen_n = 0; ren_n = 0;
    for (int c = 0; c < 3; c++) begin
      if (dmemWEN) wen_n++;
      if (dmemREN) ren_n++;
      dhit = (c == 2);
      step();
    end
    dhit = 1'b0;
    check("st_wen_cycles", wen_n, 32'd2);
    check("st_ren_cycles", ren_n, 32'd0);
    check("st_done_wen", {31'b0, dmemWEN}, 32'd0);
    check("st_cnt", {16'b0, memstall_cnt}, 32'd3);
    step();

    // Flushed store never reaches memory
    drive_mem(32'hC0, 1'b0, 1'b1, 1'b0, 32'h5, '0);
    regWr_ex = 1'b1; flush_ex = 1'b1;
    step();
    drive_nop(32'h9B);
    check("fl_regwr", {31'b0, regWr_me}, 32'd0);
    check("fl_stall", {31'b0, stall_me}, 32'd0);
    check("fl_wen", {31'b0, dmemWEN}, 32'd0);
    step();
    check("fl_state", {30'b0, dbg_state}, 32'd0);
    check("fl_wen2", {31'b0, dmemWEN}, 32'd0);

    // Reset during REQ
    drive_mem(32'h44, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    drive_nop(32'h9C);
    step();
    check("rr_ren_req", {31'b0, dmemREN}, 32'd1);
    RST = 1'b1;
    #1;
    check("rr_ren_drop", {31'b0, dmemREN}, 32'd0);
    step();
    check("rr_state", {30'b0, dbg_state}, 32'd0);
    check("rr_alu", ALUOut_me, '0);
    check("rr_cnt", {16'b0, memstall_cnt}, 32'd0);
    check("rr_regwr", {31'b0, regWr_me}, 32'd0);
    RST = 1'b0;
    drive_nop('0); regWr_ex = 1'b0;
    dhit = 1'b1; dload = 32'h1234_5678;
    step();
    dhit = 1'b0;
    check("rr_load_ignored", dmemload_me, '0);
    check("rr_strobes", {30'b0, dmemREN, dmemWEN}, 32'd0);

    // Load+store together: store wins; then halt is sticky
    drive_mem(32'h50, 1'b1, 1'b1, 1'b0, 32'h77, '0);
    step();
    drive_nop(32'h60); regWr_ex = 1'b0; halt_ex = 1'b1;
    wen_n = 0; ren_n = 0;
    for (int c = 0; c < 3; c++) begin
      if (dmemWEN) wen_n++;
      if (dmemREN) ren_n++;
      dhit = (c == 2);
      step();
    end
    dhit = 1'b0;
    check("bw_wen_cycles", wen_n, 32'd2);
    check("bw_ren_cycles", ren_n, 32'd0);
    step();
    check("ht_halt", {31'b0, halt_me}, 32'd1);
    drive_mem(32'h70, 1'b1, 1'b0, 1'b0, '0, '0);
    step();
    check("ht_regwr", {31'b0, regWr_me}, 32'd0);
    check("ht_sticky", {31'b0, halt_me}, 32'd1);
    check("ht_stall", {31'b0, stall_me}, 32'd0);
    step();
    check("ht_strobes", {30'b0, dmemREN, dmemWEN}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
